// File: rtl/seq_mult8_if.sv
// seq_mult8_if: start/done handshake and operand/result bus
// for the shift-add multiplier.
interface seq_mult8_if;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult8.sv
// seq_mult8: 8x8 unsigned shift-add multiplier, one add per clock.
// Optional macro SEQ_MULT8_ZERO_SKIP_EN: zero operands finish in 1 cycle.
module fulladder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carryin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [8:0] c;

   assign c[0] = carryin;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[8];
endmodule

module seq_mult8 (
   input  logic        clk,
   input  logic        reset,
   seq_mult8_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [7:0]  m;
   logic [7:0]  p_hi;
   logic [7:0]  p_lo;
   logic [3:0]  cnt;
   logic [15:0] prod_q;
   logic [7:0]  sum;
   logic        cout;
   logic [15:0] p_step;
   logic        zero_op;
   logic        last;

   fulladder8 u_add (
      .a       (p_hi),
      .b       (m),
      .carryin (1'b0),
      .sum     (sum),
      .cout    (cout)
   );

   // carry lands in P_hi[7] so the product stays exact
   assign p_step = p_lo[0] ? {cout, sum, p_lo[7:1]}
                           : {1'b0, p_hi, p_lo[7:1]};

`ifdef SEQ_MULT8_ZERO_SKIP_EN
   assign zero_op = (bus.a == 8'd0) || (bus.b == 8'd0);
`else
   assign zero_op = 1'b0;
`endif

   assign last = (cnt == 4'd7);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.start)
               state_nx = zero_op ? DONE : CALC;
         end
         CALC: begin
            if (last)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m      <= 8'd0;
         p_hi   <= 8'd0;
         p_lo   <= 8'd0;
         cnt    <= 4'd0;
         prod_q <= 16'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  m    <= bus.a;
                  p_hi <= 8'd0;
                  p_lo <= bus.b;
                  cnt  <= 4'd0;
                  if (zero_op)
                     prod_q <= 16'd0;
               end
            end
            CALC: begin
               {p_hi, p_lo} <= p_step;
               cnt          <= cnt + 4'd1;
               if (last)
                  prod_q <= p_step;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == CALC);
   assign bus.done    = (state == DONE);
   assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8: scoreboard bench for seq_mult8; expected products
// and due cycles are queued at accept and retired on done.
module tb_seq_mult8;
   logic clk;
   logic reset;

   seq_mult8_if bus ();

   seq_mult8 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] prod;
      int          due;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          mon_en = 0;
   logic [15:0] last_prod = 16'd0;
   logic        p_reset = 1'b1;
   logic        p_start = 1'b0;
   logic        p_busy = 1'b0;
   logic        p_done = 1'b0;
   logic [7:0]  p_a = 8'd0;
   logic [7:0]  p_b = 8'd0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h",
                  tag, cyc, obs, exp);
      end
   endtask

   function automatic int lat_of(input logic [7:0] x,
                                 input logic [7:0] y);
`ifdef SEQ_MULT8_ZERO_SKIP_EN
      if (x == 8'd0 || y == 8'd0)
         return 1;
`endif
      return 8;
   endfunction

   // accept = start seen while neither busy nor done, no reset
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic exp_done;
         logic exp_busy;
         cyc++;
         if (p_reset) begin
            sb.delete();
            last_prod = 16'd0;
         end else if (p_start && !p_busy && !p_done) begin
            e.prod = 16'(p_a) * 16'(p_b);
            e.lat  = lat_of(p_a, p_b);
            e.due  = cyc + e.lat;
            sb.push_back(e);
         end
         while (sb.size() > 0 && sb[0].due < cyc)
            void'(sb.pop_front());
         exp_done = (sb.size() > 0) && (sb[0].due == cyc);
         exp_busy = (sb.size() > 0) && (sb[0].lat == 8)
                    && (cyc < sb[0].due);
         if (exp_done) begin
            last_prod = sb[0].prod;
            void'(sb.pop_front());
         end
         check("done", 32'(bus.done), 32'(exp_done));
         check("busy", 32'(bus.busy), 32'(exp_busy));
         check("product", 32'(bus.product), 32'(last_prod));
      end
      p_reset = reset;
      p_start = bus.start;
      p_busy  = bus.busy;
      p_done  = bus.done;
      p_a     = bus.a;
      p_b     = bus.b;
   end

   task automatic go(input logic [7:0] x, input logic [7:0] y);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
   endtask

   task automatic drain();
      int i;
      @(negedge clk);
      #1;
      i = 0;
      while (sb.size() > 0 && i < 30) begin
         @(negedge clk);
         #1;
         i++;
      end
      check("drain", sb.size(), 0);
   endtask

   logic [7:0] ta[6];
   logic [7:0] tb_[6];

   initial begin
      ta  = '{8'd13, 8'd255, 8'd0,   8'd128, 8'd1,   8'd200};
      tb_ = '{8'd11, 8'd255, 8'd200, 8'd2,   8'd255, 8'd0};
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = 8'd0;
      bus.b     = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         go(ta[i], tb_[i]);
         drain();
      end

      // start held through CALC and DONE
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.a     = 8'd6;
      bus.b     = 8'd7;
      @(posedge clk);
      #1;
      bus.a = 8'd9;
      bus.b = 8'd9;
      repeat (11) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain();
      check("held_second", 32'(bus.product), 32'd81);

      // reset mid-CALC discards the operation
      go(8'd200, 8'd3);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_product", 32'(bus.product), 32'd0);
      go(8'd2, 8'd3);
      drain();
      check("after_abort", 32'(bus.product), 32'd6);

      // reset and start on the same edge
      @(posedge clk);
      #1;
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.a     = 8'd5;
      bus.b     = 8'd5;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      repeat (12) @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         go(8'($urandom), 8'($urandom));
         drain();
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
